// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register plus IF/ID latch with stall hold and single-bubble redirect flush.
// Define MIPS_FETCH_STALL_COUNT_EN to add the saturating stall_count output.
module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP      = 32'h00000020
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [9:0]  imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] ifid_ir,
   output logic [31:0] ifid_pc4,
`ifdef MIPS_FETCH_STALL_COUNT_EN
   output logic [15:0] stall_count,
`endif
   output logic        ifid_valid
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // Redirect outranks stall: a taken branch squashes the held instruction anyway.
   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (redirect) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         ir_d    = NOP;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
      end else if (!stall) begin
         pc_d    = pc_plus4;
         ir_d    = imem_rdata;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc_q    <= RESET_PC;
         ir_q    <= NOP;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

`ifdef MIPS_FETCH_STALL_COUNT_EN
   logic [15:0] stall_count_q, stall_count_d;

   // Counts only stalls that actually held the pipe; saturates rather than wrapping.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && !redirect && (stall_count_q != 16'hFFFF))
         stall_count_d = stall_count_q + 16'd1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         stall_count_q <= 16'd0;
      else
         stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`endif

   assign imem_addr  = pc_q[11:2];
   assign pc         = pc_q;
   assign ifid_ir    = ir_q;
   assign ifid_pc4   = pc4_q;
   assign ifid_valid = valid_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage: directed scenarios plus randomized stall/redirect/reset traffic.
module tb_mips_fetch_stage;

   localparam logic [31:0] NOP_W = 32'h00000020;

   logic        clock = 1'b0;
   logic        resetn = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc, ifid_ir, ifid_pc4;
   logic        ifid_valid;
`ifdef MIPS_FETCH_STALL_COUNT_EN
   logic [15:0] stall_count;
`endif

   logic [31:0] mem [1024];
   int n_checks = 0;
   int n_err = 0;

   // Reference state, expressed directly in terms of the architectural rules.
   logic [31:0] m_pc, m_ir, m_pc4;
   logic        m_valid;
   int          m_cnt;

   mips_fetch_stage dut (
      .clock(clock), .resetn(resetn), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .pc(pc), .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4),
`ifdef MIPS_FETCH_STALL_COUNT_EN
      .stall_count(stall_count),
`endif
      .ifid_valid(ifid_valid)
   );

   always #5 clock = ~clock;

   assign imem_rdata = mem[imem_addr];

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_pc <= 32'd0; m_ir <= NOP_W; m_pc4 <= 32'd0; m_valid <= 1'b0; m_cnt <= 0;
      end else if (redirect) begin
         m_pc <= redirect_pc & ~32'd3; m_ir <= NOP_W; m_pc4 <= 32'd0; m_valid <= 1'b0;
      end else if (stall) begin
         if (m_cnt < 65535) m_cnt <= m_cnt + 1;
      end else begin
         m_ir <= mem[(m_pc / 4) % 1024];
         m_pc <= m_pc + 32'd4;
         m_pc4 <= m_pc + 32'd4;
         m_valid <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", {22'd0, imem_addr}, (m_pc / 4) % 1024);
      chk("ifid_ir", ifid_ir, m_ir);
      chk("ifid_pc4", ifid_pc4, m_pc4);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
`ifdef MIPS_FETCH_STALL_COUNT_EN
      chk("stall_count", {16'd0, stall_count}, m_cnt);
`endif
   end

   task automatic step();
      @(posedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic reset_pulse();
      resetn = 1'b0;
      #1;
      chk("async_rst_pc", pc, 32'd0);
      chk("async_rst_ir", ifid_ir, NOP_W);
      chk("async_rst_pc4", ifid_pc4, 32'd0);
      chk("async_rst_valid", {31'd0, ifid_valid}, 32'd0);
`ifdef MIPS_FETCH_STALL_COUNT_EN
      chk("async_rst_cnt", {16'd0, stall_count}, 32'd0);
`endif
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = 32'h00412820;
      mem[1] = 32'h8ca30004;
      #1 resetn = 1'b0;
      #2;
      chk("rst_pc", pc, 32'd0);
      chk("rst_ir", ifid_ir, NOP_W);
      chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
      @(negedge clock);
      #1 resetn = 1'b1;

      // Reset release and first two fetches
      step();
      chk("f1_ir", ifid_ir, 32'h00412820);
      chk("f1_pc4", ifid_pc4, 32'd4);
      chk("f1_pc", pc, 32'd4);
      chk("f1_valid", {31'd0, ifid_valid}, 32'd1);
      step();
      chk("f2_ir", ifid_ir, 32'h8ca30004);
      chk("f2_pc", pc, 32'd8);

      // Two stall edges hold everything
      stall = 1'b1;
      step(); step();
      stall = 1'b0;
      chk("stall_pc", pc, 32'd8);
      chk("stall_ir", ifid_ir, 32'h8ca30004);
      chk("stall_valid", {31'd0, ifid_valid}, 32'd1);
`ifdef MIPS_FETCH_STALL_COUNT_EN
      chk("stall_cnt2", {16'd0, stall_count}, 32'd2);
`endif
      step();
      chk("post_stall_pc", pc, 32'd12);
      chk("post_stall_ir", ifid_ir, mem[2]);

      // Redirect with unaligned target, then fetch of word 8
      redirect = 1'b1; redirect_pc = 32'h00000022;
      step();
      redirect = 1'b0;
      chk("redir_pc", pc, 32'h00000020);
      chk("redir_ir", ifid_ir, 32'h00000020);
      chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
      chk("redir_pc4", ifid_pc4, 32'd0);
      step();
      chk("redir_next_ir", ifid_ir, mem[8]);
      chk("redir_next_pc4", ifid_pc4, 32'h24);

      // Redirect wins over simultaneous stall
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0; stall = 1'b0;
      chk("rs_pc", pc, 32'h40);
      chk("rs_valid", {31'd0, ifid_valid}, 32'd0);
`ifdef MIPS_FETCH_STALL_COUNT_EN
      chk("rs_cnt", {16'd0, stall_count}, 32'd2);
`endif

      // Back-to-back redirects: last one wins; then async reset at pc=0x10
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      redirect_pc = 32'h10;
      step();
      redirect = 1'b0;
      chk("b2b_pc", pc, 32'h10);
      reset_pulse();
      step();
      chk("rst_refetch_ir", ifid_ir, 32'h00412820);

      // PC wrap at 2^32 and imem index wrap at 1024 words
      redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
      step();
      redirect = 1'b0;
      step();
      chk("wrap_pc", pc, 32'd0);
      chk("wrap_ir", ifid_ir, mem[1023]);
      chk("wrap_pc4", ifid_pc4, 32'd0);
      redirect = 1'b1; redirect_pc = 32'h00001000;
      step();
      redirect = 1'b0;
      chk("wrap_idx", {22'd0, imem_addr}, 32'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         stall = ($urandom_range(0, 9) < 3);
         redirect = ($urandom_range(0, 9) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : {20'd0, $urandom_range(0, 4095)};
         if ($urandom_range(0, 199) == 0) reset_pulse();
         step();
      end
      stall = 1'b0; redirect = 1'b0;

`ifdef MIPS_FETCH_STALL_COUNT_EN
      // Saturation: stall until the counter reaches FFFE, then three more edges
      stall = 1'b1;
      for (int c = 0; c < 70000 && m_cnt < 65534; c++) step();
      chk("sat_pre", {16'd0, stall_count}, 32'hFFFE);
      step(); step(); step();
      chk("sat_cnt", {16'd0, stall_count}, 32'hFFFF);
      redirect = 1'b1; redirect_pc = 32'h80;
      step();
      chk("sat_redir_cnt", {16'd0, stall_count}, 32'hFFFF);
      stall = 1'b0; redirect = 1'b0;
`endif
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/mips_fetch_stage.md
MIPS_FETCH_STAGE -- requirements
Module: mips_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP, default 32'h00000020, SHALL be the instruction word inserted into IF/ID on reset and flush.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 stall  input  1  SHALL be the load-use hold request from the hazard unit; holds PC and IF/ID.
REQ-006 redirect  input  1  SHALL be the taken-BEQ indication from the downstream stage.
REQ-007 redirect_pc  input  32  SHALL be the branch target byte address.
REQ-008 imem_addr  output  10  SHALL be the instruction-memory word index, equal to pc[11:2].
REQ-009 imem_rdata  input  32  SHALL be the combinational instruction-memory read data for imem_addr.
REQ-010 pc  output  32  SHALL be the current fetch PC.
REQ-011 ifid_ir  output  32  SHALL be the IF/ID instruction latch feeding decode.
REQ-012 ifid_pc4  output  32  SHALL be the PC+4 of the instruction held in ifid_ir.
REQ-013 ifid_valid  output  1  SHALL be high when ifid_ir holds a fetched instruction, low for an inserted NOP.
REQ-014 stall_count  output  16  SHALL be the saturating stall-cycle count (present only with the macro).

Function
REQ-015 Per-edge priority SHALL be: redirect > stall > normal fetch.
REQ-016 Normal fetch: pc <= pc+4; ifid_ir <= imem_rdata; ifid_pc4 <= pc+4; ifid_valid <= 1.
REQ-017 Stall (redirect=0): pc, ifid_ir, ifid_pc4, ifid_valid SHALL all hold their values.
REQ-018 Redirect: pc <= {redirect_pc[31:2],2'b00}; ifid_ir <= NOP; ifid_pc4 <= 0; ifid_valid <= 0 (single-bubble flush).
REQ-019 Redirect with stall asserted SHALL behave exactly as redirect alone; the stall is dropped.
REQ-020 Fetch latency SHALL be one cycle: the word at imem_addr in cycle N appears on ifid_ir after edge N.
REQ-021 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-022 imem_addr SHALL wrap naturally at 1024 words (pc 32'h00001000 -> index 0).
REQ-023 imem_addr SHALL be purely combinational from pc; no other output SHALL be combinational from inputs.
REQ-024 Consecutive redirects on back-to-back cycles SHALL each take effect; the last one wins.

Reset
REQ-025 While resetn=0: pc=RESET_PC, ifid_ir=NOP, ifid_pc4=0, ifid_valid=0, stall_count=0, independent of clock.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL override both immediately.
REQ-027 First rising edge after resetn deasserts with stall=0, redirect=0 SHALL fetch the word at RESET_PC.

Configuration
REQ-028 Macro MIPS_FETCH_STALL_COUNT_EN defined: stall_count port exists; increments by 1 on each edge with stall=1 and redirect=0; saturates at 16'hFFFF; unaffected by redirect.
REQ-029 Macro MIPS_FETCH_STALL_COUNT_EN undefined: stall_count port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset release, imem holds 32'h00412820 at 0 and 32'h8ca30004 at 1 -> after edge 1 ifid_ir=32'h00412820, ifid_pc4=4, pc=4; after edge 2 ifid_ir=32'h8ca30004, pc=8.
REQ-031 pc=8, stall=1 for 2 edges -> pc stays 8, ifid_ir unchanged, ifid_valid unchanged; stall_count=2 (macro on).
REQ-032 pc=12, redirect=1, redirect_pc=32'h00000022 -> pc=32'h00000020, ifid_ir=32'h00000020, ifid_valid=0; next edge fetches word 8.
REQ-033 redirect=1 and stall=1 together, redirect_pc=32'h40 -> pc=32'h40, flush applied, stall_count unchanged.
REQ-034 resetn pulsed low between edges while pc=32'h10 -> pc=0, ifid_ir=NOP, ifid_valid=0 without a clock edge.
REQ-035 Force stall_count to 16'hFFFE, stall=1 for 3 edges -> stall_count=16'hFFFF and holds.
